rd_stream_adapter: RTL and testbench
====================================

# rd_stream_adapter

Read-side drain stage that sits directly downstream of the async FIFO read port in the `rclk` domain. It issues `rden` against `rd_empty`, absorbs the FIFO's one-cycle read latency in a small circular buffer, and presents the words on a valid/ready stream. Sustained throughput is one word per cycle. It also provides a flush and a delivered-word counter for the read-side scoreboard and debug.

## Interface
Parameters:
- `BUF_DEPTH`, default 3: skid buffer entries. Minimum 3, which is required for full throughput with one in-flight read.
- `CNT_W`, default 32: width of the delivered-word counter.
- `DATASIZE`: taken from `pkg_graybin`, not redeclared.

Ports:
- `rclk`  in  1: read-domain clock. All state updates on posedge.
- `rrst`  in  1: reset, synchronous, active-high.
- `rden`  out  1: FIFO read enable, sampled by the FIFO at posedge `rclk`.
- `odata`  in  DATASIZE: FIFO read data, valid in the cycle after the edge that sampled `rden`=1.
- `rd_empty`  in  1: FIFO empty flag, `rclk` domain.
- `flush`  in  1: discard all buffered and in-flight words.
- `m_valid`  out  1: stream data valid.
- `m_data`  out  DATASIZE: stream data.
- `m_ready`  in  1: downstream accepts the word.
- `buf_level`  out  $clog2(BUF_DEPTH+1): current buffer occupancy.
- `words_out`  out  CNT_W: count of words accepted downstream, wrapping.

## Operation
- State:
  - `occ` (0..BUF_DEPTH)
  - `wr_ptr` and `rd_ptr` (0..BUF_DEPTH-1, wrap to 0 after BUF_DEPTH-1)
  - `inflight` (1 bit; equals `rden` at the previous edge)
  - `words_out`
  - storage array `buf[BUF_DEPTH]`
- Read request: `rden` = !`rrst` && !`flush` && !`rd_empty` && (`occ` + `inflight` < BUF_DEPTH). It depends on registered state and current inputs only; there is no path from `m_ready` to `rden`.
- Capture: at an edge with `inflight`=1 and `flush`=0, `buf[wr_ptr]` <= `odata` and `wr_ptr` advances.
- Output: `m_valid` = (`occ` != 0); `m_data` = `buf[rd_ptr]`.
- Pop: at an edge with `m_valid` && `m_ready` && !`flush`, `rd_ptr` advances and `words_out` increments. `words_out` wraps from 2^CNT_W-1 to 0.
- `occ` update: +1 on capture only, -1 on pop only, unchanged on capture+pop in the same cycle.
- Overflow never occurs by construction, because (`occ` + `inflight`) ≤ BUF_DEPTH is invariant. This is an assertion target.
- Flush: in the flush cycle `rden`=0. At the edge: `occ`, `wr_ptr`, `rd_ptr` and `inflight` go to 0, and the `odata` word valid in that cycle is dropped. `words_out` is not cleared and not incremented, even if `m_ready`=1.
- `buf_level` = `occ`.

## Timing
- Reset values: `rden`=0 (combinationally while `rrst`=1), `m_valid`=0, `buf_level`=0, `words_out`=0, `inflight`=0. `m_data` contents are don't-care, but must not be X-propagated into any control signal.
- Reset mid-operation: the in-flight word and all buffered words are lost. `rden` is first re-asserted in the first cycle with `rrst`=0.
- Latency with an empty buffer: `rden`=1 in cycle N, then `odata` valid in N+1 and captured at the end of N+1, then `m_valid`=1 in N+2. That is 2 cycles from request to output.
- Steady state with `m_ready` held at 1 and the FIFO non-empty: `rden`=1 every cycle, one word per cycle, `occ` oscillating at 1.
- `m_ready`=0 with the FIFO non-empty: `rden` stops once `occ` + `inflight` reaches BUF_DEPTH, and `occ` settles at BUF_DEPTH.
- Stream rule: while `m_valid` && !`m_ready`, `m_data` and `m_valid` stay stable.
- `rd_empty` rising in the same cycle as a candidate read: `rden`=0 that cycle and no word is requested.
- `flush` and `rrst` both high: reset behaviour applies, so `words_out` is cleared.

## Structure
- `pkg_graybin` already provides `DATASIZE`; this block adds no new package items.
- The buffer is a natural sub-module, `rd_skid_buf` (storage, pointers, occupancy; push/pop/clear inputs).
- The top level holds only the `rden` logic, `inflight`, and `words_out`.
- Verification extends the existing read interface with a monitor clocking block on `m_valid`, `m_data` and `m_ready`.

## Test plan
- **Reset, then 4 words in the FIFO, `m_ready`=1:** `rden` is high for 4 cycles starting in the first cycle after reset. `m_valid` first appears 2 cycles after the first `rden`. Words come out in order, back-to-back, and `words_out` ends at 4.
- **FIFO holds 8 words, `m_ready`=0:** exactly 3 `rden` pulses, then `buf_level`=3 and `rden`=0. Releasing `m_ready` then delivers all 8 words in order with no gaps after the first.
- **Toggle `m_ready` 1/0 each cycle with the FIFO non-empty:** no word is lost or duplicated, `m_data` stays stable during stalls, and `buf_level` never exceeds 3.
- **Assert `flush` with `buf_level`=2 and `inflight`=1:** next cycle `m_valid`=0, `buf_level`=0, and `words_out` is unchanged. The next word requested after the flush is the first word delivered.
- **`rrst` asserted mid-stream with `words_out`=0x10:** next cycle all outputs are at reset values and `words_out`=0. `rden`=0 throughout the reset cycles.
- **Preload `words_out` to 0xFFFF_FFFF via a stream of 2^32-1 words (or force), then deliver one more word:** `words_out`=0.

Source files
------------

// File: rtl/pkg_graybin.sv
// Shared read-path definitions for the gray/binary async FIFO slice.
package pkg_graybin;
    localparam int DATASIZE = 8;
endpackage

// File: rtl/rd_skid_buf.sv
// Circular skid buffer that absorbs the FIFO read latency.
module rd_skid_buf
    import pkg_graybin::*;
#(
    parameter int DEPTH = 3,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic                rclk,
    input  logic                clr,
    input  logic                push,
    input  logic                pop,
    input  logic [DATASIZE-1:0] din,
    output logic [DATASIZE-1:0] dout,
    output logic                valid,
    output logic [LW-1:0]       occ
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge rclk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            unique case (1'b1)
                push && !pop: occ <= occ + LW'(1);
                pop && !push: occ <= occ - LW'(1);
                default:      occ <= occ;
            endcase
        end
    end

    // Storage carries no reset; contents are only read while occ != 0.
    always_ff @(posedge rclk) begin
        if (push && !clr) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign valid = (occ != '0);

endmodule

// File: rtl/rd_stream_adapter.sv
// Drains the async FIFO read port into a valid/ready stream at one word per cycle.
module rd_stream_adapter
    import pkg_graybin::*;
#(
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = 32
) (
    input  logic                           rclk,
    input  logic                           rrst,
    output logic                           rden,
    input  logic [DATASIZE-1:0]            odata,
    input  logic                           rd_empty,
    input  logic                           flush,
    output logic                           m_valid,
    output logic [DATASIZE-1:0]            m_data,
    input  logic                           m_ready,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_level,
    output logic [CNT_W-1:0]               words_out
);

    localparam int LW = $clog2(BUF_DEPTH + 1);
    localparam logic [LW:0] DEPTH_V = (LW + 1)'(BUF_DEPTH);

    logic          inflight;
    logic [LW-1:0] occ;
    logic [LW:0]   pending;
    logic          clr;
    logic          push;
    logic          pop;

    // Occupancy plus the word already requested bounds the next request.
    assign pending = {1'b0, occ} + (LW + 1)'(inflight);
    assign rden    = !rrst && !flush && !rd_empty && (pending < DEPTH_V);

    assign clr  = rrst || flush;
    assign push = inflight && !flush;
    assign pop  = m_valid && m_ready && !flush;

    rd_skid_buf #(
        .DEPTH (BUF_DEPTH),
        .LW    (LW)
    ) u_buf (
        .rclk  (rclk),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (odata),
        .dout  (m_data),
        .valid (m_valid),
        .occ   (occ)
    );

    always_ff @(posedge rclk) begin
        if (rrst) begin
            inflight  <= 1'b0;
            words_out <= '0;
        end else begin
            inflight <= rden;
            if (pop) words_out <= words_out + CNT_W'(1);
        end
    end

    assign buf_level = occ;

    no_overflow: assert property (
        @(posedge rclk) disable iff (rrst) pending <= DEPTH_V
    );

endmodule

// File: tb/tb_rd_stream_adapter.sv
// Scoreboard bench: FIFO model drives the adapter, a monitor checks the stream.
module tb_rd_stream_adapter;
    import pkg_graybin::*;

    localparam int DEPTH = 3;
    localparam int CW    = 8;

    logic                rclk = 1'b0;
    logic                rrst = 1'b1;
    logic                rden;
    logic [DATASIZE-1:0] odata = '0;
    logic                rd_empty = 1'b1;
    logic                flush = 1'b0;
    logic                m_valid;
    logic [DATASIZE-1:0] m_data;
    logic                m_ready = 1'b0;
    logic [1:0]          buf_level;
    logic [CW-1:0]       words_out;

    always #5 rclk = ~rclk;

    rd_stream_adapter #(
        .BUF_DEPTH (DEPTH),
        .CNT_W     (CW)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rden      (rden),
        .odata     (odata),
        .rd_empty  (rd_empty),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .buf_level (buf_level),
        .words_out (words_out)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    logic [DATASIZE-1:0] fifo_q [$];
    logic [DATASIZE-1:0] exp_q [$];
    logic [DATASIZE-1:0] seq = '0;
    logic                rden_l = 1'b0;
    logic                odata_vld = 1'b0;

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(seq);
            seq = seq + 1'b1;
        end
        if (n > 0) rd_empty = 1'b0;
    endtask

    // FIFO read port: a read sampled at an edge presents data one cycle later.
    always @(posedge rclk) begin
        #1;
        if (rden_l && fifo_q.size() > 0) begin
            odata     = fifo_q.pop_front();
            odata_vld = 1'b1;
        end else begin
            odata_vld = 1'b0;
        end
        rd_empty = (fifo_q.size() == 0);
    end

    // Reference: every word read survives unless a flush or reset hits
    // the cycle it is on the bus or any later cycle before delivery.
    always @(negedge rclk) begin
        rden_l = rden;
        chk("rden_when_empty", 32'(rden & rd_empty), 32'(0));
        chk("rden_in_reset", 32'(rden & rrst), 32'(0));
        if (rrst || flush) exp_q.delete();
        else if (odata_vld) exp_q.push_back(odata);
    end

    logic [CW-1:0]       exp_words = '0;
    logic                stall_p = 1'b0;
    logic [DATASIZE-1:0] stall_d = '0;

    always @(negedge rclk) begin
        chk("words_out", 32'(words_out), 32'(exp_words));
        chk("buf_level_max", 32'(buf_level > 2'(DEPTH)), 32'(0));
        if (stall_p) begin
            chk("stall_valid", 32'(m_valid), 32'(1));
            chk("stall_data", 32'(m_data), 32'(stall_d));
        end
        if (!rrst && !flush && m_valid && m_ready) begin
            chk("word_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0)
                chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            exp_words = exp_words + 1'b1;
        end
        if (rrst) exp_words = '0;
        stall_p = m_valid && !m_ready && !rrst && !flush;
        stall_d = m_data;
    end

    task automatic cyc();
        @(posedge rclk);
        #2;
    endtask

    task automatic drain(input int lim);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < lim && !idle; i++) begin
            @(negedge rclk);
            idle = fifo_q.size() == 0 && !rden && !odata_vld &&
                   !m_valid && exp_q.size() == 0;
        end
        chk("drain_done", 32'(idle), 32'(1));
    endtask

    logic exp_rden [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_mv   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int            cnt;
        logic [CW-1:0] wsave;

        m_ready = 1'b1;
        repeat (3) @(negedge rclk);
        chk("rst_rden", 32'(rden), 32'(0));
        chk("rst_valid", 32'(m_valid), 32'(0));
        chk("rst_level", 32'(buf_level), 32'(0));
        cyc();
        push_words(4);
        cyc();
        rrst = 1'b0;

        // Four words, m_ready high: 2-cycle latency, back-to-back output.
        for (int i = 0; i < 7; i++) begin
            @(negedge rclk);
            chk("t1_rden", 32'(rden), 32'(exp_rden[i]));
            chk("t1_valid", 32'(m_valid), 32'(exp_mv[i]));
        end
        chk("t1_words", 32'(words_out), 32'(4));

        // Eight words, m_ready low: buffer fills to depth.
        cyc();
        m_ready = 1'b0;
        push_words(8);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge rclk);
            cnt += int'(rden);
        end
        chk("t2_pulses", 32'(cnt), 32'(3));
        chk("t2_level", 32'(buf_level), 32'(3));
        chk("t2_rden_off", 32'(rden), 32'(0));
        cyc();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge rclk);
            chk("t2_gapless", 32'(m_valid), 32'(1));
        end
        @(negedge rclk);
        chk("t2_empty", 32'(m_valid), 32'(0));
        chk("t2_words", 32'(words_out), 32'(12));

        // Toggling m_ready.
        cyc();
        push_words(20);
        for (int i = 0; i < 60; i++) begin
            m_ready = !m_ready;
            cyc();
        end
        m_ready = 1'b1;
        drain(300);

        // Flush with two buffered and one in flight.
        cyc();
        m_ready = 1'b0;
        push_words(10);
        repeat (3) cyc();
        flush = 1'b1;
        @(negedge rclk);
        chk("t4_pre_level", 32'(buf_level), 32'(2));
        wsave = words_out;
        cyc();
        flush = 1'b0;
        @(negedge rclk);
        chk("t4_valid", 32'(m_valid), 32'(0));
        chk("t4_level", 32'(buf_level), 32'(0));
        chk("t4_words", 32'(words_out), 32'(wsave));
        cyc();
        m_ready = 1'b1;
        drain(300);

        // Reset mid-stream with words_out at 0x10, flush also high.
        cyc();
        rrst = 1'b1;
        cyc();
        rrst = 1'b0;
        push_words(16);
        drain(300);
        chk("t5_pre_words", 32'(words_out), 32'h10);
        cyc();
        m_ready = 1'b0;
        push_words(6);
        repeat (6) cyc();
        rrst = 1'b1;
        @(negedge rclk);
        chk("t5_rden0", 32'(rden), 32'(0));
        cyc();
        flush = 1'b1;
        @(negedge rclk);
        chk("t5_rden1", 32'(rden), 32'(0));
        chk("t5_valid", 32'(m_valid), 32'(0));
        chk("t5_level", 32'(buf_level), 32'(0));
        chk("t5_words", 32'(words_out), 32'(0));
        cyc();
        rrst = 1'b0;
        flush = 1'b0;
        @(negedge rclk);
        chk("t5_rden_after", 32'(rden), 32'(1));
        cyc();
        m_ready = 1'b1;
        drain(300);

        // Counter wrap: 2^CW words from zero.
        cyc();
        rrst = 1'b1;
        cyc();
        rrst = 1'b0;
        push_words(1 << CW);
        drain(800);
        chk("t6_wrap", 32'(words_out), 32'(0));

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            cyc();
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 32)
                push_words($urandom_range(1, 3));
            flush = ($urandom_range(0, 49) == 0);
            rrst  = ($urandom_range(0, 299) == 0);
        end
        cyc();
        flush = 1'b0;
        rrst = 1'b0;
        m_ready = 1'b1;
        drain(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
